// File: rtl/mod_counter.sv
// Modulo up/down counter with synchronous clamped load, terminal-count pulse and
// optional prescaler (enabled by defining MOD_COUNTER_PRESCALER_EN).
module mod_counter #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned MODULUS  = 1024,
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned SATURATE = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Tick
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_next;
    logic             tc_next;

`ifdef MOD_COUNTER_PRESCALER_EN
    localparam int unsigned PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;
    logic [PW-1:0] p_next;

    // Prescaler phase holds while disabled; a load restarts the full period.
    always_comb begin
        p_next = p;
        if (Load) begin
            p_next = '0;
        end else if (En) begin
            p_next = (p == P_LAST) ? '0 : p + PW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            p <= '0;
        end else begin
            p <= p_next;
        end
    end

    assign Tick = En & (p == P_LAST);
`else
    assign Tick = En;
`endif

    // Load wins over stepping; Tc flags each step taken at an end of the range.
    always_comb begin
        q_next  = Q;
        tc_next = 1'b0;
        if (Load) begin
            q_next = (D > MAX_Q) ? MAX_Q : D;
        end else if (Tick) begin
            if (Up) begin
                if (Q == MAX_Q) begin
                    tc_next = 1'b1;
                    if (SATURATE == 0) begin
                        q_next = '0;
                    end
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end else begin
                if (Q == '0) begin
                    tc_next = 1'b1;
                    if (SATURATE == 0) begin
                        q_next = MAX_Q;
                    end
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q  <= '0;
            Tc <= 1'b0;
        end else begin
            Q  <= q_next;
            Tc <= tc_next;
        end
    end

endmodule
